routing_state_controller: RTL and testbench
===========================================

Name: routing_state_controller

Overview:
- Owns the node's routing state, this-node ID and parent ID registers.
- Drives the `routing_state` / `this_node_id` inputs of system_flit_decoder_comb and consumes that decoder's update strobes.
- In GENERATE states it emits parent-request and join-request system flits to the outbound flit arbiter.
- Retries on ack timeout; enters FATAL_ERROR after too many retries.

Parameters:
- IS_ROOT, 0, node is tree root: starts in NORMAL and never generates requests.
- ROOT_ID, 0, node ID loaded on reset when IS_ROOT=1; also reset value of parent_id.
- BROADCAST_ID, '1, dst_id used for parent-request flits.
- ACK_TIMEOUT, 256, cycles waited in a WAIT state before retry (1..65535).
- MAX_RETRY, 4, number of timeouts tolerated per phase; the next timeout goes to FATAL_ERROR.

Ports:
- nocclk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- init_node_id  input  types::node_id_t  temporary (random) ID loaded on reset when IS_ROOT=0
- update_next_state  input  1  decoder strobe: take next_routing_state
- next_routing_state  input  system_types::routing_state_t  decoder's requested state
- update_parent_valid  input  1  load parent_id
- update_parent_node_id  input  types::node_id_t  new parent ID
- update_this_node_valid  input  1  load this_node_id
- update_this_node_id  input  types::node_id_t  new node ID
- rejoin_req  input  1  one-cycle pulse: parent lost, re-attach keeping current ID
- routing_state  output  system_types::routing_state_t  current state
- this_node_id  output  types::node_id_t  current node ID
- parent_id  output  types::node_id_t  current parent ID
- flit_out  output  types::flit_t  generated system flit
- flit_out_valid  output  1  flit_out holds a valid flit
- flit_out_ready  input  1  downstream accepts flit_out this cycle
- fatal_error  output  1  high while in FATAL_ERROR

Behaviour:
- Reset values:
  - IS_ROOT=1: routing_state=NORMAL, this_node_id=ROOT_ID.
  - IS_ROOT=0: routing_state=I_GENERATE_PARENT_REQUEST, this_node_id=init_node_id sampled at reset.
  - Both cases: parent_id=ROOT_ID, flit_out_valid=0, flit_out=0, fatal_error=0, timer=0, retry count=0.
- State types: routing_state_t includes I_/S_GENERATE_PARENT_REQUEST, I_/S_WAIT_PARENT_ACK, I_/S_GENERATE_JOIN_REQUEST, I_/S_WAIT_JOIN_ACK, NORMAL, FATAL_ERROR. I_ = initial join, S_ = rejoin.
- GENERATE_PARENT_REQUEST:
  - flit_out_valid=1, flittype SYSTEM, header S_PARENT_REQUEST, src_id=this_node_id, dst_id=BROADCAST_ID.
  - payload.parent_request.is_init = 1 for I_, 0 for S_.
  - On the flit_out_ready handshake, next cycle: flit_out_valid=0, state=matching WAIT_PARENT_ACK, timer=ACK_TIMEOUT.
- GENERATE_JOIN_REQUEST:
  - Header S_JOIN_REQUEST, src_id=this_node_id, dst_id=parent_id.
  - join_request.child_id=this_node_id; is_init as above.
  - Handshake moves to matching WAIT_JOIN_ACK with timer=ACK_TIMEOUT.
- Flit output handshake:
  - Once asserted, flit_out_valid and flit_out are held stable until ready.
  - flit_out is registered, so valid rises 1 cycle after entering a GENERATE state.
  - No flit is generated in any other state.
- WAIT states:
  - Timer decrements by 1 per cycle.
  - update_next_state=1: routing_state<=next_routing_state next cycle, retry count cleared.
  - Timer reaching 0 with no update:
    - retry count < MAX_RETRY: retry count+1, return to the GENERATE state of the same phase (parent or join).
    - otherwise: FATAL_ERROR.
  - update_next_state in the same cycle as the timeout: the update wins.
- update_next_state is ignored outside WAIT states.
- update_parent_valid / update_this_node_valid:
  - Registers load next cycle in any non-FATAL state; ignored when IS_ROOT=1.
  - May coincide with update_next_state; all take effect together.
- NORMAL:
  - rejoin_req with IS_ROOT=0 goes to S_GENERATE_PARENT_REQUEST; this_node_id is kept and retry count cleared.
  - rejoin_req is ignored in all other states and when IS_ROOT=1.
- FATAL_ERROR: sticky until rst_n; fatal_error=1, flit_out_valid=0; all strobes ignored.
- Reset asserted mid-handshake: valid drops immediately (asynchronous); a flit may be lost, and the bench must not expect it.

Test Plan:
- IS_ROOT=0, init_node_id=0x2A, ready=1:
  - Expect valid within 2 cycles after reset release, PARENT_REQUEST src=0x2A dst=BROADCAST_ID is_init=1.
  - State then I_WAIT_PARENT_ACK.
- Parent-ack path:
  - In I_WAIT_PARENT_ACK drive update_next_state (next=I_GENERATE_JOIN_REQUEST) plus update_parent_valid id=0x05.
  - Expect JOIN_REQUEST dst=0x05 child_id=0x2A.
  - Then update_this_node 0x11 with next=NORMAL: expect this_node_id=0x11, state NORMAL.
- Backpressure:
  - Hold flit_out_ready=0 for 10 cycles in GENERATE.
  - Expect flit_out stable, valid=1 throughout, state unchanged; handshake on cycle 11.
- Timeout:
  - ACK_TIMEOUT=8, MAX_RETRY=2, never ack.
  - Expect 3 parent-request flits spaced by the timeout, then FATAL_ERROR; later strobes ignored.
- Race:
  - Timer hits 0 in the same cycle as update_next_state (next=I_GENERATE_JOIN_REQUEST).
  - Expect the join phase, no retry.
  - Then rejoin_req in NORMAL: expect S_ PARENT_REQUEST is_init=0 with the same this_node_id.
- IS_ROOT=1:
  - Expect NORMAL and this_node_id=ROOT_ID after reset.
  - rejoin_req/update strobes produce no flit and no state change.

Source files
------------

// File: rtl/noc_types_pkg.sv
// Shared NoC types: node IDs, the system flit format and the routing states
// driven into system_flit_decoder_comb.

package types;

    typedef logic [7:0] node_id_t;

    typedef enum logic [1:0] {
        DATA   = 2'd0,
        SYSTEM = 2'd1
    } flittype_t;

    typedef enum logic [2:0] {
        S_NONE           = 3'd0,
        S_PARENT_REQUEST = 3'd1,
        S_PARENT_ACK     = 3'd2,
        S_JOIN_REQUEST   = 3'd3,
        S_JOIN_ACK       = 3'd4
    } sys_header_t;

    typedef struct packed {
        logic        is_init;
        logic [14:0] rsvd;
    } parent_request_t;

    typedef struct packed {
        node_id_t    child_id;
        logic        is_init;
        logic [6:0]  rsvd;
    } join_request_t;

    typedef union packed {
        parent_request_t parent_request;
        join_request_t   join_request;
    } payload_t;

    typedef struct packed {
        flittype_t   flittype;
        sys_header_t header;
        node_id_t    src_id;
        node_id_t    dst_id;
        payload_t    payload;
    } flit_t;

endpackage

package system_types;

    // I_ states belong to the initial join, S_ states to a rejoin after the
    // parent was lost.
    typedef enum logic [3:0] {
        I_GENERATE_PARENT_REQUEST = 4'd0,
        I_WAIT_PARENT_ACK         = 4'd1,
        I_GENERATE_JOIN_REQUEST   = 4'd2,
        I_WAIT_JOIN_ACK           = 4'd3,
        S_GENERATE_PARENT_REQUEST = 4'd4,
        S_WAIT_PARENT_ACK         = 4'd5,
        S_GENERATE_JOIN_REQUEST   = 4'd6,
        S_WAIT_JOIN_ACK           = 4'd7,
        NORMAL                    = 4'd8,
        FATAL_ERROR               = 4'd9
    } routing_state_t;

endpackage

// File: rtl/routing_state_controller_if.sv
// Valid/ready flit channel from a flit source (master) towards the outbound
// flit arbiter (slave).

interface routing_state_controller_if;
    import types::*;

    flit_t flit_out;
    logic  flit_out_valid;
    logic  flit_out_ready;

    modport master (
        output flit_out,
        output flit_out_valid,
        input  flit_out_ready
    );

    modport slave (
        input  flit_out,
        input  flit_out_valid,
        output flit_out_ready
    );

endinterface

// File: rtl/routing_state_controller.sv
// Routing state controller: owns routing state, this-node ID and parent ID,
// generates parent/join request system flits while joining the tree, retries
// on ack timeout and locks into FATAL_ERROR after too many retries.

module routing_state_controller
    import types::*, system_types::*;
#(
    parameter bit          IS_ROOT      = 1'b0,
    parameter node_id_t    ROOT_ID      = '0,
    parameter node_id_t    BROADCAST_ID = '1,
    parameter int unsigned ACK_TIMEOUT  = 256,
    parameter int unsigned MAX_RETRY    = 4
) (
    input  logic                         nocclk,
    input  logic                         rst_n,
    input  node_id_t                     init_node_id,
    input  logic                         update_next_state,
    input  routing_state_t               next_routing_state,
    input  logic                         update_parent_valid,
    input  node_id_t                     update_parent_node_id,
    input  logic                         update_this_node_valid,
    input  node_id_t                     update_this_node_id,
    input  logic                         rejoin_req,
    output routing_state_t               routing_state,
    output node_id_t                     this_node_id,
    output node_id_t                     parent_id,
    routing_state_controller_if.master   flit_port,
    output logic                         fatal_error
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [15:0]        TIMER_LOAD = 16'(ACK_TIMEOUT);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    routing_state_t     state_q, state_nxt;
    logic [15:0]        timer_q, timer_nxt;
    logic [RETRY_W-1:0] retry_q, retry_nxt;
    node_id_t           this_id_q, parent_id_q;
    flit_t              flit_q, flit_nxt;
    logic               valid_q, valid_nxt;

    logic in_gen_parent, in_gen_join, is_init_phase, handshake;

    assign in_gen_parent = (state_q == I_GENERATE_PARENT_REQUEST) ||
                           (state_q == S_GENERATE_PARENT_REQUEST);
    assign in_gen_join   = (state_q == I_GENERATE_JOIN_REQUEST) ||
                           (state_q == S_GENERATE_JOIN_REQUEST);
    assign is_init_phase = (state_q == I_GENERATE_PARENT_REQUEST) ||
                           (state_q == I_WAIT_PARENT_ACK)         ||
                           (state_q == I_GENERATE_JOIN_REQUEST)   ||
                           (state_q == I_WAIT_JOIN_ACK);
    assign handshake     = valid_q && flit_port.flit_out_ready;

    // GENERATE state that a WAIT state falls back to after a timeout.
    function automatic routing_state_t retry_target(input routing_state_t s);
        case (s)
            I_WAIT_PARENT_ACK: return I_GENERATE_PARENT_REQUEST;
            S_WAIT_PARENT_ACK: return S_GENERATE_PARENT_REQUEST;
            I_WAIT_JOIN_ACK:   return I_GENERATE_JOIN_REQUEST;
            default:           return S_GENERATE_JOIN_REQUEST;
        endcase
    endfunction

    // State register plus the registered ID and flit outputs.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this_node_id loads init_node_id asynchronously, so
            // init_node_id must be held stable until rst_n is released.
            state_q     <= IS_ROOT ? NORMAL : I_GENERATE_PARENT_REQUEST;
            this_id_q   <= IS_ROOT ? ROOT_ID : init_node_id;
            parent_id_q <= ROOT_ID;
            timer_q     <= '0;
            retry_q     <= '0;
            flit_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q <= state_nxt;
            timer_q <= timer_nxt;
            retry_q <= retry_nxt;
            flit_q  <= flit_nxt;
            valid_q <= valid_nxt;
            if (!IS_ROOT && state_q != FATAL_ERROR) begin
                if (update_parent_valid)    parent_id_q <= update_parent_node_id;
                if (update_this_node_valid) this_id_q   <= update_this_node_id;
            end
        end
    end

    // Next-state logic: request handshakes, ack wait with timeout/retry, rejoin.
    always_comb begin
        // NOTE: defaulting every output first means no path leaves a variable
        // unassigned, so no latch can be inferred.
        state_nxt = state_q;
        timer_nxt = timer_q;
        retry_nxt = retry_q;
        case (state_q)
            I_GENERATE_PARENT_REQUEST, S_GENERATE_PARENT_REQUEST: begin
                if (handshake) begin
                    state_nxt = is_init_phase ? I_WAIT_PARENT_ACK : S_WAIT_PARENT_ACK;
                    timer_nxt = TIMER_LOAD;
                end
            end
            I_GENERATE_JOIN_REQUEST, S_GENERATE_JOIN_REQUEST: begin
                if (handshake) begin
                    state_nxt = is_init_phase ? I_WAIT_JOIN_ACK : S_WAIT_JOIN_ACK;
                    timer_nxt = TIMER_LOAD;
                end
            end
            I_WAIT_PARENT_ACK, S_WAIT_PARENT_ACK, I_WAIT_JOIN_ACK, S_WAIT_JOIN_ACK: begin
                // A decoder update beats a timeout landing in the same cycle.
                if (update_next_state) begin
                    state_nxt = next_routing_state;
                    retry_nxt = '0;
                    timer_nxt = TIMER_LOAD;
                end else if (timer_q == '0) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_nxt = retry_q + 1'b1;
                        state_nxt = retry_target(state_q);
                    end else begin
                        state_nxt = FATAL_ERROR;
                    end
                end else begin
                    timer_nxt = timer_q - 16'd1;
                end
            end
            NORMAL: begin
                if (rejoin_req && !IS_ROOT) begin
                    state_nxt = S_GENERATE_PARENT_REQUEST;
                    retry_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    // Output logic: build the request flit on GENERATE entry, hold it until accepted.
    always_comb begin
        flit_nxt  = '0;
        valid_nxt = 1'b0;
        if (in_gen_parent || in_gen_join) begin
            if (handshake) begin
                valid_nxt = 1'b0;
            end else if (valid_q) begin
                valid_nxt = 1'b1;
                flit_nxt  = flit_q;
            end else begin
                valid_nxt         = 1'b1;
                flit_nxt.flittype = SYSTEM;
                flit_nxt.src_id   = this_id_q;
                if (in_gen_parent) begin
                    flit_nxt.header                         = S_PARENT_REQUEST;
                    flit_nxt.dst_id                         = BROADCAST_ID;
                    flit_nxt.payload.parent_request.is_init = is_init_phase;
                end else begin
                    flit_nxt.header                        = S_JOIN_REQUEST;
                    flit_nxt.dst_id                        = parent_id_q;
                    flit_nxt.payload.join_request.child_id = this_id_q;
                    flit_nxt.payload.join_request.is_init  = is_init_phase;
                end
            end
        end
    end

    assign routing_state            = state_q;
    assign this_node_id             = this_id_q;
    assign parent_id                = parent_id_q;
    assign fatal_error              = (state_q == FATAL_ERROR);
    assign flit_port.flit_out       = flit_q;
    assign flit_port.flit_out_valid = valid_q;

endmodule

// File: tb/tb_routing_state_controller.sv
// Bench for routing_state_controller: a leaf node (short timeout) and a root
// node. Expected flits are queued when stimulus is driven and compared as the
// DUT hands them off.

module tb_routing_state_controller;
    import types::*;
    import system_types::*;

    localparam node_id_t BCAST  = 8'hFF;
    localparam node_id_t R_ID   = 8'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Leaf node signals
    node_id_t       init_id, upd_par_id, upd_this_id;
    logic           upd_ns, upd_par_v, upd_this_v, rejoin;
    routing_state_t next_rs, rs;
    node_id_t       tid, pid;
    logic           fatal;
    routing_state_controller_if f_if();

    // Root node signals
    logic           r_upd_ns, r_upd_par_v, r_upd_this_v, r_rejoin;
    routing_state_t r_next_rs, r_rs;
    node_id_t       r_tid, r_pid;
    logic           r_fatal;
    routing_state_controller_if r_if();

    routing_state_controller #(
        .IS_ROOT(1'b0), .ROOT_ID(8'h00), .BROADCAST_ID(BCAST),
        .ACK_TIMEOUT(8), .MAX_RETRY(2)
    ) dut (
        .nocclk(clk), .rst_n(rst_n), .init_node_id(init_id),
        .update_next_state(upd_ns), .next_routing_state(next_rs),
        .update_parent_valid(upd_par_v), .update_parent_node_id(upd_par_id),
        .update_this_node_valid(upd_this_v), .update_this_node_id(upd_this_id),
        .rejoin_req(rejoin), .routing_state(rs), .this_node_id(tid),
        .parent_id(pid), .flit_port(f_if.master), .fatal_error(fatal)
    );

    routing_state_controller #(
        .IS_ROOT(1'b1), .ROOT_ID(R_ID), .BROADCAST_ID(BCAST),
        .ACK_TIMEOUT(8), .MAX_RETRY(2)
    ) dut_root (
        .nocclk(clk), .rst_n(rst_n), .init_node_id(8'h99),
        .update_next_state(r_upd_ns), .next_routing_state(r_next_rs),
        .update_parent_valid(r_upd_par_v), .update_parent_node_id(8'h44),
        .update_this_node_valid(r_upd_this_v), .update_this_node_id(8'h55),
        .rejoin_req(r_rejoin), .routing_state(r_rs), .this_node_id(r_tid),
        .parent_id(r_pid), .flit_port(r_if.master), .fatal_error(r_fatal)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    flit_t sb[$];
    int    hs_cyc[$];

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic flit_t exp_parent(input node_id_t src, input logic init);
        flit_t f;
        f = '0;
        f.flittype = SYSTEM;
        f.header   = S_PARENT_REQUEST;
        f.src_id   = src;
        f.dst_id   = BCAST;
        f.payload.parent_request.is_init = init;
        return f;
    endfunction

    function automatic flit_t exp_join(input node_id_t src, input node_id_t dst, input logic init);
        flit_t f;
        f = '0;
        f.flittype = SYSTEM;
        f.header   = S_JOIN_REQUEST;
        f.src_id   = src;
        f.dst_id   = dst;
        f.payload.join_request.child_id = src;
        f.payload.join_request.is_init  = init;
        return f;
    endfunction

    // Scoreboard: every accepted leaf flit must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && f_if.flit_out_valid && f_if.flit_out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                check("flit", f_if.flit_out, sb.pop_front());
                hs_cyc.push_back(cyc);
            end
        end
        if (rst_n && r_if.flit_out_valid)
            check("root_flit_valid", r_if.flit_out_valid, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        upd_ns = 0; upd_par_v = 0; upd_this_v = 0; rejoin = 0;
        r_upd_ns = 0; r_upd_par_v = 0; r_upd_this_v = 0; r_rejoin = 0;
    endtask

    task automatic wait_state(input routing_state_t target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rs == target) break;
        end
        check(tag, rs, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic  seen;
        flit_t held;

        clear_strobes();
        next_rs = NORMAL; r_next_rs = NORMAL;
        upd_par_id = '0; upd_this_id = '0;
        init_id = 8'h2A;
        f_if.flit_out_ready = 1'b1;
        r_if.flit_out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_state", rs, I_GENERATE_PARENT_REQUEST);
        check("rst_this_id", tid, 8'h2A);
        check("rst_parent_id", pid, 8'h00);
        check("rst_valid", f_if.flit_out_valid, 1'b0);
        check("rst_flit", f_if.flit_out, '0);
        check("rst_fatal", fatal, 1'b0);
        check("root_rst_state", r_rs, NORMAL);
        check("root_rst_this_id", r_tid, R_ID);
        check("root_rst_parent_id", r_pid, R_ID);

        // Initial parent request
        sb.push_back(exp_parent(8'h2A, 1'b1));
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            seen = f_if.flit_out_valid;
        end
        check("first_valid_latency", seen, 1'b1);
        wait_state(I_WAIT_PARENT_ACK, 4, "i_wait_parent");
        check("valid_drop_after_hs", f_if.flit_out_valid, 1'b0);

        // Parent ack together with parent id update
        upd_ns = 1; next_rs = I_GENERATE_JOIN_REQUEST;
        upd_par_v = 1; upd_par_id = 8'h05;
        sb.push_back(exp_join(8'h2A, 8'h05, 1'b1));
        tick(); clear_strobes();
        check("ack_to_join_state", rs, I_GENERATE_JOIN_REQUEST);
        check("parent_loaded", pid, 8'h05);
        wait_state(I_WAIT_JOIN_ACK, 4, "i_wait_join");

        // Join ack with new node ID
        upd_this_v = 1; upd_this_id = 8'h11;
        upd_ns = 1; next_rs = NORMAL;
        tick(); clear_strobes();
        check("this_id_loaded", tid, 8'h11);
        check("normal_state", rs, NORMAL);

        // update_next_state ignored outside WAIT states
        upd_ns = 1; next_rs = FATAL_ERROR;
        tick(); clear_strobes();
        check("ns_ignored_normal", rs, NORMAL);

        // Rejoin under backpressure
        f_if.flit_out_ready = 1'b0;
        rejoin = 1;
        sb.push_back(exp_parent(8'h11, 1'b0));
        tick(); clear_strobes();
        check("rejoin_state", rs, S_GENERATE_PARENT_REQUEST);
        tick();
        check("bp_valid_rise", f_if.flit_out_valid, 1'b1);
        held = f_if.flit_out;
        repeat (10) begin
            tick();
            check("bp_valid", f_if.flit_out_valid, 1'b1);
            check("bp_flit_stable", f_if.flit_out, held);
            check("bp_state", rs, S_GENERATE_PARENT_REQUEST);
        end
        f_if.flit_out_ready = 1'b1;
        tick();
        check("bp_hs_state", rs, S_WAIT_PARENT_ACK);

        // Race: update arrives in the cycle the timer reads zero
        repeat (8) tick();
        check("race_pre_state", rs, S_WAIT_PARENT_ACK);
        upd_ns = 1; next_rs = I_GENERATE_JOIN_REQUEST;
        sb.push_back(exp_join(8'h11, 8'h05, 1'b1));
        tick(); clear_strobes();
        check("race_update_wins", rs, I_GENERATE_JOIN_REQUEST);
        wait_state(I_WAIT_JOIN_ACK, 4, "race_wait_join");
        upd_ns = 1; next_rs = NORMAL;
        tick(); clear_strobes();
        check("race_normal", rs, NORMAL);

        // Rejoin from NORMAL keeps this_node_id
        rejoin = 1;
        sb.push_back(exp_parent(8'h11, 1'b0));
        tick(); clear_strobes();
        check("rejoin2_state", rs, S_GENERATE_PARENT_REQUEST);
        check("rejoin2_keep_id", tid, 8'h11);
        wait_state(S_WAIT_PARENT_ACK, 4, "rejoin2_wait");
        check("sb_drained_1", sb.size(), 0);

        // Timeout and retry exhaustion
        rst_n = 1'b0;
        tick(); tick();
        check("rst2_valid", f_if.flit_out_valid, 1'b0);
        hs_cyc.delete();
        repeat (3) sb.push_back(exp_parent(8'h2A, 1'b1));
        rst_n = 1'b1;
        wait_state(FATAL_ERROR, 60, "fatal_reached");
        check("retry_flit_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("retry_spacing_1", hs_cyc[1] - hs_cyc[0], 11);
            check("retry_spacing_2", hs_cyc[2] - hs_cyc[1], 11);
        end
        check("sb_drained_2", sb.size(), 0);
        check("fatal_flag", fatal, 1'b1);
        check("fatal_valid", f_if.flit_out_valid, 1'b0);

        // FATAL_ERROR is sticky
        upd_ns = 1; next_rs = NORMAL;
        upd_par_v = 1; upd_par_id = 8'h77;
        upd_this_v = 1; upd_this_id = 8'h66;
        rejoin = 1;
        repeat (3) tick();
        clear_strobes();
        tick();
        check("fatal_sticky_state", rs, FATAL_ERROR);
        check("fatal_keep_this_id", tid, 8'h2A);
        check("fatal_keep_parent", pid, 8'h00);
        check("fatal_sticky_valid", f_if.flit_out_valid, 1'b0);

        // Root ignores rejoin and update strobes
        r_rejoin = 1; r_upd_ns = 1; r_next_rs = I_GENERATE_PARENT_REQUEST;
        r_upd_par_v = 1; r_upd_this_v = 1;
        repeat (3) tick();
        clear_strobes();
        repeat (2) tick();
        check("root_state", r_rs, NORMAL);
        check("root_this_id", r_tid, R_ID);
        check("root_parent_id", r_pid, R_ID);
        check("root_valid", r_if.flit_out_valid, 1'b0);
        check("root_fatal", r_fatal, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
